param_mc_core: RTL and testbench
================================

// Module: param_mc_core
// PURPOSE
//  Parametrised multicycle core: next generation of the 8-bit register_bank/instr_bank/decoder/ALU/control_unit set, merged into one block.
//  Internal register file (2**AW x DW), instruction store (2**PCW x IW), 3-bit opcode ALU with Z/C flags, conditional branch, HALT.
//  FSM: IDLE->FETCH->DECODE->EXECUTE->WRITEBACK. Program/data loaded through side ports while idle; start runs from PC 0.
// PARAMETERS
//  DW   8  datapath / register width (>=2)
//  AW   2  register address bits; NREG = 2**AW
//  PCW  4  PC width; instruction depth = 2**PCW
//  IW   derived localparam = 3+2*AW; instr = {op[2:0], rd[AW-1:0], rs[AW-1:0]}
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      async, active-high; clears all state
//  start      in   1      1-cycle pulse; honoured only in IDLE or HALT
//  prog_we    in   1      write instruction store (ignored unless IDLE/HALT)
//  prog_addr  in   PCW    instruction store address
//  prog_data  in   IW     instruction word
//  reg_we     in   1      write register file (ignored unless IDLE/HALT)
//  reg_addr   in   AW     register write address
//  reg_wdata  in   DW     register write data
//  dbg_raddr  in   AW     debug read address
//  dbg_rdata  out  DW     combinational regfile[dbg_raddr]
//  busy       out  1      1 in FETCH/DECODE/EXECUTE/WRITEBACK
//  halted     out  1      1 in HALT
//  pc         out  PCW    program counter
//  state      out  3      IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 WRITEBACK=4 HALT=5
//  alu_out    out  DW     registered result of last EXECUTE
//  zero       out  1      Z flag
//  carry      out  1      C flag
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, alu_out=0, zero=0, carry=0, busy=0, halted=0, IR=0, regfile and instr store cleared to 0.
//  Reset mid-instruction aborts immediately; no partial writeback.
//  IDLE/HALT + start: pc<=0, flags kept, ->FETCH. Load ports written same edge if asserted with start.
//  FETCH: IR<=imem[pc]. DECODE: A<=reg[rd], B<=reg[rs].
//  EXECUTE (op): 000 ADD {C,R}=A+B; 001 SUB R=A-B, C=(A<B) borrow;
//   010 AND, 011 OR, 100 XOR, 101 NOT R=~B: C<=0.
//   ALU ops: alu_out<=R, Z<=(R==0).
//   110 BZ: no flag/alu_out change; target={rd,rs} zero-extended/truncated to PCW.
//   111 HALT: ->HALT; pc not incremented, no WB.
//  WRITEBACK: ALU ops reg[rd]<=alu_out; pc<=pc+1 (wraps 2**PCW-1 -> 0).
//   BZ: pc<=Z ? target : pc+1.
//  Timing: ALU/BZ instr = 4 cycles; HALT = 3 cycles then HALT state.
//  Load writes while busy are dropped; start while busy ignored.
//  rd==rs legal (SUB r,r -> 0, Z=1, C=0). DW-bit arithmetic wraps modulo 2**DW.
//  HALT holds all outputs until start or reset; regfile readable via dbg port.
// TESTING (defaults DW=8 AW=2 PCW=4; IW=7)
//  1 Reset: reset=1 mid-EXECUTE -> state=0, pc=0, alu_out=0, zero=0, carry=0, busy=0, dbg_rdata=0 for all regs.
//  2 Program: r0=1 r1=2 r2=2 r3=0; imem 0:7'h01 ADD r0,r1; 1:7'h1A SUB r2,r2; 2:7'h64 BZ 4; 3:7'h00; 4:7'h70 HALT.
//    start -> halted=1 exactly 15 edges after start edge; r0=3, r2=0, zero=1, carry=0, pc=4; imem[3] never fetched.
//  3 Carry/borrow: r0=8'hFF r1=8'h01, ADD r0,r1 -> r0=0, Z=1, C=1; then SUB r1,r0 (1-0)=1, C=0; SUB r0,r1 -> 8'hFF, C=1.
//  4 PC wrap: imem all 7'h00 except pc15=7'h00 and pc0 = HALT on 2nd pass via reload -> pc wraps 15->0 after WB, no X.
//  5 Busy lockout: prog_we/reg_we/start pulsed during FETCH..WRITEBACK -> imem/regfile unchanged, sequence timing unchanged.
//  6 Restart: start in HALT -> FETCH with pc=0, flags retained from previous run.

Source files
------------

// File: rtl/param_mc_if.sv
// Control, load and observation bundle for param_mc_core.
// The master drives stimulus and load ports; the slave is the core.
interface param_mc_if #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 2,
  parameter int unsigned PCW = 4
);
  localparam int unsigned IW = 3 + 2 * AW;

  logic           start;
  logic           prog_we;
  logic [PCW-1:0] prog_addr;
  logic [IW-1:0]  prog_data;
  logic           reg_we;
  logic [AW-1:0]  reg_addr;
  logic [DW-1:0]  reg_wdata;
  logic [AW-1:0]  dbg_raddr;
  logic [DW-1:0]  dbg_rdata;
  logic           busy;
  logic           halted;
  logic [PCW-1:0] pc;
  logic [2:0]     state;
  logic [DW-1:0]  alu_out;
  logic           zero;
  logic           carry;

  modport master (
    output start, prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, dbg_raddr,
    input  dbg_rdata, busy, halted, pc, state, alu_out, zero, carry
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data, reg_we, reg_addr, reg_wdata, dbg_raddr,
    output dbg_rdata, busy, halted, pc, state, alu_out, zero, carry
  );
endinterface

// File: rtl/param_mc_core.sv
// Multicycle accumulator-free core: regfile, instruction store, 3-bit ALU with Z/C,
// conditional branch and HALT, sequenced FETCH -> DECODE -> EXECUTE -> WRITEBACK.
module param_mc_core #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 2,
  parameter int unsigned PCW = 4
) (
  input  logic        clk,
  input  logic        reset,
  param_mc_if.slave   bus
);
  localparam int unsigned IW   = 3 + 2 * AW;
  localparam int unsigned TW   = 2 * AW;
  localparam int unsigned NREG = 2 ** AW;
  localparam int unsigned NINS = 2 ** PCW;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpNot  = 3'b101;
  localparam logic [2:0] OpBz   = 3'b110;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5
  } state_e;

  state_e         state_q;
  logic [PCW-1:0] pc_q;
  logic [IW-1:0]  ir_q;
  logic [DW-1:0]  a_q, b_q, alu_q;
  logic           zero_q, carry_q;
  logic [DW-1:0]  regs_q [NREG];
  logic [IW-1:0]  imem_q [NINS];

  logic [2:0]     op;
  logic [AW-1:0]  rd, rs;
  logic [PCW-1:0] target, pc_inc;
  logic [DW:0]    sum;
  logic [DW-1:0]  alu_res;
  logic           alu_c;
  logic           load_ok;

  assign op      = ir_q[IW-1 -: 3];
  assign rd      = ir_q[TW-1 -: AW];
  assign rs      = ir_q[AW-1:0];
  assign pc_inc  = pc_q + PCW'(1);
  assign load_ok = (state_q == StIdle) || (state_q == StHalt);

  // Branch target is the {rd,rs} field fitted to the PC width.
  if (PCW >= TW) begin : g_tgt_ext
    assign target = PCW'(ir_q[TW-1:0]);
  end else begin : g_tgt_trunc
    assign target = ir_q[PCW-1:0];
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    case (op)
      OpAdd: {alu_c, alu_res} = sum;
      OpSub: begin
        alu_res = a_q - b_q;
        alu_c   = (a_q < b_q);
      end
      OpAnd:   alu_res = a_q & b_q;
      OpOr:    alu_res = a_q | b_q;
      OpXor:   alu_res = a_q ^ b_q;
      OpNot:   alu_res = ~b_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      for (int i = 0; i < NINS; i++) imem_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (bus.prog_we) imem_q[bus.prog_addr] <= bus.prog_data;
          if (bus.reg_we)  regs_q[bus.reg_addr]  <= bus.reg_wdata;
          if (bus.start) begin
            pc_q    <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          ir_q    <= imem_q[pc_q];
          state_q <= StDecode;
        end
        StDecode: begin
          a_q     <= regs_q[rd];
          b_q     <= regs_q[rs];
          state_q <= StExecute;
        end
        StExecute: begin
          if (op == OpHalt) begin
            state_q <= StHalt;
          end else begin
            // BZ leaves flags and alu_out untouched so it tests the previous result.
            if (op != OpBz) begin
              alu_q   <= alu_res;
              zero_q  <= (alu_res == '0);
              carry_q <= alu_c;
            end
            state_q <= StWriteback;
          end
        end
        StWriteback: begin
          if (op == OpBz) begin
            pc_q <= zero_q ? target : pc_inc;
          end else begin
            regs_q[rd] <= alu_q;
            pc_q       <= pc_inc;
          end
          state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy      = (state_q == StFetch) || (state_q == StDecode) ||
                         (state_q == StExecute) || (state_q == StWriteback);
  assign bus.halted    = (state_q == StHalt);
  assign bus.pc        = pc_q;
  assign bus.state     = state_q;
  assign bus.alu_out   = alu_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.dbg_rdata = regs_q[bus.dbg_raddr];

endmodule

// File: tb/tb_param_mc_core.sv
// Scoreboard bench for param_mc_core: each program run queues its expected end state,
// and a monitor compares it when the core enters HALT.
module tb_param_mc_core;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_mc_if #(.DW(8), .AW(2), .PCW(4)) bus ();

  param_mc_core #(.DW(8), .AW(2), .PCW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]      pc;
    logic            z;
    logic            c;
    logic [7:0]      alu;
    logic [3:0][7:0] r;
    int              cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         start_cyc = 0;
  logic       mon_own = 1'b0;
  logic [1:0] mon_raddr = '0;
  logic [1:0] main_raddr = '0;

  assign bus.dbg_raddr = mon_own ? mon_raddr : main_raddr;

  always @(posedge clk) cyc++;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic [3:0] pc, logic z, logic c, logic [7:0] alu,
                              logic [7:0] r0, logic [7:0] r1, logic [7:0] r2,
                              logic [7:0] r3, int cy);
    exp_t e;
    e.pc = pc; e.z = z; e.c = c; e.alu = alu;
    e.r = {r3, r2, r1, r0};
    e.cyc = cy;
    return e;
  endfunction

  // Monitor: on each entry into HALT pop and compare the oldest expectation.
  initial begin : monitor
    logic prev = 1'b0;
    logic h;
    exp_t e;
    forever begin
      @(negedge clk);
      h = bus.halted;
      if (h && !prev) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_halt: got halt expected none");
        end else begin
          e = sb_q.pop_front();
          check("halt_cycles", cyc - start_cyc, e.cyc);
          check("pc", bus.pc, e.pc);
          check("zero", bus.zero, e.z);
          check("carry", bus.carry, e.c);
          check("alu_out", bus.alu_out, e.alu);
          mon_own = 1'b1;
          for (int i = 0; i < 4; i++) begin
            mon_raddr = 2'(i);
            #1;
            check($sformatf("r%0d", i), bus.dbg_rdata, e.r[i]);
          end
          mon_own = 1'b0;
        end
      end
      prev = h;
    end
  end

  task automatic idle_inputs();
    bus.start = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.reg_we = 0; bus.reg_addr = '0; bus.reg_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.reg_we = 1; bus.reg_addr = a; bus.reg_wdata = d;
    @(negedge clk);
    bus.reg_we = 0;
  endtask

  task automatic load_ins(input logic [3:0] a, input logic [6:0] d);
    @(negedge clk);
    bus.prog_we = 1; bus.prog_addr = a; bus.prog_data = d;
    @(negedge clk);
    bus.prog_we = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 0;
  endtask

  // Run from pc 0 to HALT; with lock set, hammer load/start ports while busy.
  task automatic run(input exp_t e, input bit lock);
    int k;
    sb_q.push_back(e);
    pulse_start();
    check("start_state", bus.state, 3'd1);
    check("start_pc", bus.pc, 4'd0);
    k = 0;
    while (k < 100 && !bus.halted) begin
      @(negedge clk);
      if (lock && bus.busy) begin
        bus.start = 1;
        bus.prog_we = 1; bus.prog_addr = 4'd4; bus.prog_data = 7'h00;
        bus.reg_we = 1;  bus.reg_addr = 2'd3;  bus.reg_wdata = 8'hAA;
      end else begin
        idle_inputs();
      end
      k++;
    end
    idle_inputs();
    if (!bus.halted) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: got no halt expected halt within 100 cycles");
      void'(sb_q.pop_back());
      do_reset();
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic load_prog2();
    load_reg(2'd0, 8'd1); load_reg(2'd1, 8'd2); load_reg(2'd2, 8'd2); load_reg(2'd3, 8'd0);
    load_ins(4'd0, 7'h01); load_ins(4'd1, 7'h1A); load_ins(4'd2, 7'h64);
    load_ins(4'd3, 7'h00); load_ins(4'd4, 7'h70);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #3;
    check("rst_state", bus.state, 3'd0);
    check("rst_pc", bus.pc, 4'd0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset mid-EXECUTE of the second instruction, after the first has written back.
    load_prog2();
    pulse_start();
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_state", bus.state, 3'd3);
    check("pre_rst_alu", bus.alu_out, 8'd3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_state", bus.state, 3'd0);
    check("mid_rst_pc", bus.pc, 4'd0);
    check("mid_rst_alu", bus.alu_out, 8'd0);
    check("mid_rst_zero", bus.zero, 1'b0);
    check("mid_rst_carry", bus.carry, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      main_raddr = 2'(i);
      #1;
      check($sformatf("mid_rst_r%0d", i), bus.dbg_rdata, 8'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Branch-taken program; imem[3] would double r0 if fetched.
    do_reset();
    load_prog2();
    run(mk(4'd4, 1, 0, 8'h00, 8'd3, 8'd2, 8'd0, 8'd0, 15), 1'b0);

    // Same program with load/start ports pulsed throughout the busy window.
    do_reset();
    load_prog2();
    run(mk(4'd4, 1, 0, 8'h00, 8'd3, 8'd2, 8'd0, 8'd0, 15), 1'b1);

    // Carry and borrow, one op per run; flags and regs carry over between runs.
    do_reset();
    load_reg(2'd0, 8'hFF); load_reg(2'd1, 8'h01);
    load_ins(4'd0, 7'h01); load_ins(4'd1, 7'h70);
    run(mk(4'd1, 1, 1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 7), 1'b0);
    load_ins(4'd0, 7'h14);
    run(mk(4'd1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 7), 1'b0);
    load_ins(4'd0, 7'h11);
    run(mk(4'd1, 0, 1, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 7), 1'b0);

    // Restart straight into HALT: flags and alu_out retained from the previous run.
    load_ins(4'd0, 7'h70);
    run(mk(4'd0, 0, 1, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 3), 1'b0);

    // PC wrap: set Z, then BZ 15 -> OR at 15 clears Z and wraps to 0 -> BZ falls to HALT at 1.
    do_reset();
    load_reg(2'd1, 8'h01);
    load_ins(4'd0, 7'h10); load_ins(4'd1, 7'h70);
    run(mk(4'd1, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 7), 1'b0);
    load_ins(4'd0, 7'h6F); load_ins(4'd15, 7'h35);
    run(mk(4'd1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 15), 1'b0);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
